// File: rtl/audio_pkg.sv
// Shared audio-path definitions for the WM8731 codec link (DAC transmit and ADC capture sides).
package audio_pkg;

   localparam int AUDIO_SAMPLE_W = 16;

   typedef enum logic [1:0] {
      WAIT_SYNC,
      LEFT,
      RIGHT
   } tx_state_t;

   typedef struct packed {
      logic [AUDIO_SAMPLE_W-1:0] left;
      logic [AUDIO_SAMPLE_W-1:0] right;
   } sample_pair_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a codec clock input, with one-cycle rise/fall pulses in the Clk domain.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;
   assign fall  = ~sync & prev;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified DAC serializer with a one-deep sample-pair buffer; the codec is bus master.
module i2s_dac_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_W        = AUDIO_SAMPLE_W,
   parameter int DATA_DELAY      = 1,
   parameter bit UNDERRUN_REPEAT = 1'b1
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                AUD_BCLK,
   input  logic                AUD_DACLRCK,
   input  logic [SAMPLE_W-1:0] LDATA,
   input  logic [SAMPLE_W-1:0] RDATA,
   input  logic                data_valid,
   output logic                data_ready,
   output logic                AUD_DACDAT,
   output logic                frame_start,
   output logic                underrun
);

   localparam int CNT_MAX = SAMPLE_W + DATA_DELAY;
   localparam int CW      = $clog2(CNT_MAX + 2);

   logic bclk_level, bclk_rise, bclk_fall;
   logic lr_sync, lr_rise, lr_fall;
   logic unused_edges;

   sync_edge u_bclk (.clk(Clk), .rst(Reset), .din(AUD_BCLK),
                     .level(bclk_level), .rise(bclk_rise), .fall(bclk_fall));
   sync_edge u_lrck (.clk(Clk), .rst(Reset), .din(AUD_DACLRCK),
                     .level(lr_sync), .rise(lr_rise), .fall(lr_fall));

   // LRCK is judged against its value at the previous BCLK fall, not per Clk
   assign unused_edges = ^{bclk_level, bclk_rise, lr_rise, lr_fall};

   tx_state_t           state, state_n;
   logic                lr_prev;
   logic                left_start, right_start;
   logic                load_left, load_right, advance;
   logic                buf_full;
   logic [SAMPLE_W-1:0] buf_l, buf_r, last_l, last_r, hold_r;
   logic [SAMPLE_W-1:0] shift, word;
   logic [CW-1:0]       cnt, slot;
   logic                in_window;
   logic                dat;

   assign left_start  = bclk_fall && lr_prev && !lr_sync;
   assign right_start = bclk_fall && !lr_prev && lr_sync;

   always_ff @(posedge Clk) begin
      if (Reset) state <= WAIT_SYNC;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      load_left  = 1'b0;
      load_right = 1'b0;
      advance    = 1'b0;
      case (state)
         WAIT_SYNC: begin
            if (left_start) begin
               state_n   = LEFT;
               load_left = 1'b1;
            end
         end
         LEFT, RIGHT: begin
            // Any LRCK edge restarts the channel, truncating a short half-frame
            if (left_start) begin
               state_n   = LEFT;
               load_left = 1'b1;
            end else if (right_start) begin
               state_n    = RIGHT;
               load_right = 1'b1;
            end else if (bclk_fall) begin
               advance = 1'b1;
            end
         end
         default: state_n = WAIT_SYNC;
      endcase
   end

   // slot = index of the BCLK slot being driven; 0 is the slot at the LRCK edge
   always_comb begin
      word = shift;
      slot = cnt + CW'(1);
      if (load_left) begin
         word = buf_full ? buf_l : (UNDERRUN_REPEAT ? last_l : '0);
         slot = '0;
      end else if (load_right) begin
         word = hold_r;
         slot = '0;
      end
   end

   assign in_window = (int'(slot) >= DATA_DELAY) && (int'(slot) < CNT_MAX);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lr_prev     <= 1'b0;
         shift       <= '0;
         cnt         <= '0;
         dat         <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= load_left && buf_full;
         underrun    <= load_left && !buf_full;
         if (bclk_fall) lr_prev <= lr_sync;
         if (load_left || load_right || advance) begin
            dat   <= in_window ? word[SAMPLE_W-1] : 1'b0;
            shift <= in_window ? {word[SAMPLE_W-2:0], 1'b0} : word;
            if (load_left || load_right) cnt <= '0;
            else if (cnt != CW'(CNT_MAX)) cnt <= slot;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         buf_full <= 1'b0;
         buf_l    <= '0;
         buf_r    <= '0;
         last_l   <= '0;
         last_r   <= '0;
         hold_r   <= '0;
      end else begin
         // Accept only while empty and consume only while full, so the two never collide
         if (data_valid && !buf_full) begin
            buf_full <= 1'b1;
            buf_l    <= LDATA;
            buf_r    <= RDATA;
         end
         if (load_left && buf_full) begin
            buf_full <= 1'b0;
            last_l   <= buf_l;
            last_r   <= buf_r;
            hold_r   <= buf_r;
         end else if (load_left) begin
            hold_r <= UNDERRUN_REPEAT ? last_r : '0;
         end
      end
   end

   assign data_ready = !buf_full;
   assign AUD_DACDAT = dat;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench: a codec-master model drives BCLK (Clk/16) and DACLRCK, and DACDAT is sampled on BCLK rise.
module tb_i2s_dac_tx;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Reset, AUD_BCLK, AUD_DACLRCK, data_valid;
   logic [15:0] LDATA, RDATA;
   logic        ready_a, dat_a, fs_a, ur_a;
   logic        ready_z, dat_z, fs_z, ur_z;
   logic        ready_l, dat_l, fs_l, ur_l;

   // I2S with repeat-on-underrun, I2S with zero-on-underrun, left-justified
   i2s_dac_tx dut (
      .Clk(Clk), .Reset(Reset), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
      .LDATA(LDATA), .RDATA(RDATA), .data_valid(data_valid), .data_ready(ready_a),
      .AUD_DACDAT(dat_a), .frame_start(fs_a), .underrun(ur_a));
   i2s_dac_tx #(.UNDERRUN_REPEAT(1'b0)) dut_z (
      .Clk(Clk), .Reset(Reset), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
      .LDATA(LDATA), .RDATA(RDATA), .data_valid(data_valid), .data_ready(ready_z),
      .AUD_DACDAT(dat_z), .frame_start(fs_z), .underrun(ur_z));
   i2s_dac_tx #(.DATA_DELAY(0)) dut_l (
      .Clk(Clk), .Reset(Reset), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
      .LDATA(LDATA), .RDATA(RDATA), .data_valid(data_valid), .data_ready(ready_l),
      .AUD_DACDAT(dat_l), .frame_start(fs_l), .underrun(ur_l));

   int checks = 0;
   int fails  = 0;
   int nfs_a = 0, nur_a = 0, nur_z = 0, nfs_l = 0;

   always @(posedge Clk) begin
      if (fs_a) nfs_a <= nfs_a + 1;
      if (ur_a) nur_a <= nur_a + 1;
      if (ur_z) nur_z <= nur_z + 1;
      if (fs_l) nfs_l <= nfs_l + 1;
   end

   logic [63:0] cap_a, cap_z, cap_l, lc_a, lc_z, lc_l, rc_a, rc_z, rc_l;
   logic        rst_dat;

   localparam logic [15:0] BP_L [3] = '{16'h1111, 16'hC3C3, 16'h7E81};
   localparam logic [15:0] BP_R [3] = '{16'h2222, 16'h3C3C, 16'h0101};

   // Expected slot pattern of one half-frame: word MSB-first starting at slot dd, zeros elsewhere
   function automatic logic [63:0] mk_exp(input logic [15:0] w, input int dd, input int n);
      logic [63:0] e;
      e = '0;
      for (int k = 0; k < n; k++)
         if (k >= dd && k < dd + 16) e[k] = w[15-(k-dd)];
      return e;
   endfunction

   task automatic run_half(input logic lr, input int n, input int rst_slot);
      cap_a = '0; cap_z = '0; cap_l = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge Clk);
         AUD_BCLK = 1'b0;
         if (k == 0) AUD_DACLRCK = lr;
         repeat (8) @(negedge Clk);
         AUD_BCLK = 1'b1;
         cap_a[k] = dat_a; cap_z[k] = dat_z; cap_l[k] = dat_l;
         if (k == rst_slot) begin
            Reset = 1'b1;
            @(posedge Clk);
            #1 rst_dat = dat_a;
            @(negedge Clk);
            @(negedge Clk);
            Reset = 1'b0;
            repeat (5) @(negedge Clk);
         end else begin
            repeat (7) @(negedge Clk);
         end
      end
   endtask

   task automatic run_frame(input int n);
      run_half(1'b0, n, -1);
      lc_a = cap_a; lc_z = cap_z; lc_l = cap_l;
      run_half(1'b1, n, -1);
      rc_a = cap_a; rc_z = cap_z; rc_l = cap_l;
   endtask

   task automatic load_pair(input logic [15:0] l, input logic [15:0] r);
      @(negedge Clk);
      LDATA = l; RDATA = r; data_valid = 1'b1;
      @(negedge Clk);
      data_valid = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b1; AUD_BCLK = 1'b1; AUD_DACLRCK = 1'b1;
      data_valid = 1'b0; LDATA = '0; RDATA = '0;
      repeat (4) @(negedge Clk);
      checks++; if (dat_a !== 1'b0) begin fails++; $display("FAIL reset_dacdat: got %b want 0", dat_a); end
      checks++; if (ready_a !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready_a); end
      checks++; if ({fs_a, ur_a, fs_l, ur_z} !== 4'b0) begin fails++; $display("FAIL reset_pulses: got %b want 0000", {fs_a, ur_a, fs_l, ur_z}); end
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   // Reset was released with LRCK high, so a pair loaded now must wait for the LRCK fall
   task automatic test_basic;
      int fs0;
      fs0 = nfs_a;
      load_pair(16'hA55A, 16'h1234);
      @(posedge Clk); #1;
      checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL basic_ready_drop: got %b want 0", ready_a); end
      run_half(1'b1, 12, -1);
      checks++; if (cap_a !== 64'h0) begin fails++; $display("FAIL sync_idle: got %h want 0", cap_a); end
      checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL sync_kept: got %b want 0", ready_a); end
      run_frame(32);
      checks++; if (lc_a !== mk_exp(16'hA55A, 1, 32)) begin fails++; $display("FAIL basic_left: got %h want %h", lc_a, mk_exp(16'hA55A, 1, 32)); end
      checks++; if (rc_a !== mk_exp(16'h1234, 1, 32)) begin fails++; $display("FAIL basic_right: got %h want %h", rc_a, mk_exp(16'h1234, 1, 32)); end
      checks++; if (lc_l !== mk_exp(16'hA55A, 0, 32)) begin fails++; $display("FAIL basic_left_lj: got %h want %h", lc_l, mk_exp(16'hA55A, 0, 32)); end
      checks++; if (nfs_a - fs0 !== 1) begin fails++; $display("FAIL basic_frame_start: got %0d want 1", nfs_a - fs0); end
      checks++; if (ready_a !== 1'b1) begin fails++; $display("FAIL basic_ready_back: got %b want 1", ready_a); end
   endtask

   task automatic test_underrun;
      int ua, uz;
      load_pair(16'h8001, 16'h7FFE);
      run_frame(32);
      checks++; if (lc_a !== mk_exp(16'h8001, 1, 32)) begin fails++; $display("FAIL ur_first_left: got %h want %h", lc_a, mk_exp(16'h8001, 1, 32)); end
      ua = nur_a; uz = nur_z;
      run_frame(32);
      checks++; if (nur_a - ua !== 1) begin fails++; $display("FAIL ur_pulse: got %0d want 1", nur_a - ua); end
      checks++; if (nur_z - uz !== 1) begin fails++; $display("FAIL ur_pulse_z: got %0d want 1", nur_z - uz); end
      checks++; if (lc_a !== mk_exp(16'h8001, 1, 32)) begin fails++; $display("FAIL ur_repeat_left: got %h want %h", lc_a, mk_exp(16'h8001, 1, 32)); end
      checks++; if (rc_a !== mk_exp(16'h7FFE, 1, 32)) begin fails++; $display("FAIL ur_repeat_right: got %h want %h", rc_a, mk_exp(16'h7FFE, 1, 32)); end
      checks++; if ({lc_z, rc_z} !== 128'h0) begin fails++; $display("FAIL ur_zero: got %h %h want 0", lc_z, rc_z); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] bl [3];
      logic [63:0] br [3];
      int fs0, ur0;
      bit ok;
      fs0 = nfs_a; ur0 = nur_a;
      load_pair(BP_L[0], BP_R[0]);
      @(negedge Clk);
      LDATA = BP_L[1]; RDATA = BP_R[1]; data_valid = 1'b1;
      fork
         begin
            for (int f = 0; f < 3; f++) begin
               checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL bp_ready_held f%0d: got %b want 0", f, ready_a); end
               run_frame(32);
               bl[f] = lc_a; br[f] = rc_a;
            end
         end
         begin
            for (int i = 1; i < 3; i++) begin
               LDATA = BP_L[i]; RDATA = BP_R[i]; data_valid = 1'b1;
               ok = 1'b0;
               for (int t = 0; t < 4000; t++) begin
                  @(negedge Clk);
                  if (ready_a) begin ok = 1'b1; break; end
               end
               @(negedge Clk);
               checks++; if (!ok) begin fails++; $display("FAIL bp_accept_timeout pair%0d: got no ready want ready", i); end
            end
            data_valid = 1'b0;
         end
      join
      for (int f = 0; f < 3; f++) begin
         checks++; if (bl[f] !== mk_exp(BP_L[f], 1, 32)) begin fails++; $display("FAIL bp_left f%0d: got %h want %h", f, bl[f], mk_exp(BP_L[f], 1, 32)); end
         checks++; if (br[f] !== mk_exp(BP_R[f], 1, 32)) begin fails++; $display("FAIL bp_right f%0d: got %h want %h", f, br[f], mk_exp(BP_R[f], 1, 32)); end
      end
      checks++; if (nfs_a - fs0 !== 3) begin fails++; $display("FAIL bp_frame_starts: got %0d want 3", nfs_a - fs0); end
      checks++; if (nur_a - ur0 !== 0) begin fails++; $display("FAIL bp_no_underrun: got %0d want 0", nur_a - ur0); end
      run_frame(32);
      checks++; if (nur_a - ur0 !== 1) begin fails++; $display("FAIL bp_drained: got %0d want 1", nur_a - ur0); end
      checks++; if (lc_z !== 64'h0) begin fails++; $display("FAIL bp_no_dup: got %h want 0", lc_z); end
   endtask

   task automatic test_short_lj;
      load_pair(16'hFFFF, 16'h8001);
      run_frame(24);
      checks++; if (lc_l !== mk_exp(16'hFFFF, 0, 24)) begin fails++; $display("FAIL lj_left: got %h want %h", lc_l, mk_exp(16'hFFFF, 0, 24)); end
      checks++; if (rc_l !== mk_exp(16'h8001, 0, 24)) begin fails++; $display("FAIL lj_right: got %h want %h", rc_l, mk_exp(16'h8001, 0, 24)); end
      checks++; if (lc_a !== mk_exp(16'hFFFF, 1, 24)) begin fails++; $display("FAIL i2s24_left: got %h want %h", lc_a, mk_exp(16'hFFFF, 1, 24)); end
      load_pair(16'hABCD, 16'h1357);
      run_frame(10);
      checks++; if (lc_l !== mk_exp(16'hABCD, 0, 10)) begin fails++; $display("FAIL short_left_lj: got %h want %h", lc_l, mk_exp(16'hABCD, 0, 10)); end
      checks++; if (rc_l !== mk_exp(16'h1357, 0, 10)) begin fails++; $display("FAIL short_right_lj: got %h want %h", rc_l, mk_exp(16'h1357, 0, 10)); end
      checks++; if (rc_a !== mk_exp(16'h1357, 1, 10)) begin fails++; $display("FAIL short_right: got %h want %h", rc_a, mk_exp(16'h1357, 1, 10)); end
      load_pair(16'h0F0F, 16'hF00F);
      run_frame(32);
      checks++; if (lc_l !== mk_exp(16'h0F0F, 0, 32)) begin fails++; $display("FAIL after_short_lj: got %h want %h", lc_l, mk_exp(16'h0F0F, 0, 32)); end
      checks++; if (rc_a !== mk_exp(16'hF00F, 1, 32)) begin fails++; $display("FAIL after_short: got %h want %h", rc_a, mk_exp(16'hF00F, 1, 32)); end
   endtask

   task automatic test_reset_mid_word;
      int ua;
      bit ok;
      rst_dat = 1'bx;
      load_pair(16'hFFFF, 16'hFFFF);
      fork
         run_half(1'b0, 32, 9);
         begin
            ok = 1'b0;
            for (int t = 0; t < 400; t++) begin
               @(negedge Clk);
               if (ready_a) begin ok = 1'b1; break; end
            end
            checks++; if (!ok) begin fails++; $display("FAIL rst_consume_timeout: got no ready want ready"); end
            LDATA = 16'h5555; RDATA = 16'hAAAA; data_valid = 1'b1;
            @(negedge Clk);
            data_valid = 1'b0;
            checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL rst_buffered: got %b want 0", ready_a); end
         end
      join
      checks++; if (rst_dat !== 1'b0) begin fails++; $display("FAIL rst_dacdat: got %b want 0", rst_dat); end
      checks++; if (cap_a !== 64'h3FE) begin fails++; $display("FAIL rst_left_bits: got %h want 3fe", cap_a); end
      checks++; if (cap_l !== 64'h3FF) begin fails++; $display("FAIL rst_left_bits_lj: got %h want 3ff", cap_l); end
      checks++; if (ready_a !== 1'b1) begin fails++; $display("FAIL rst_discard: got %b want 1", ready_a); end
      run_half(1'b1, 32, -1);
      checks++; if (cap_a !== 64'h0) begin fails++; $display("FAIL rst_wait_sync: got %h want 0", cap_a); end
      ua = nur_a;
      run_frame(32);
      checks++; if (nur_a - ua !== 1) begin fails++; $display("FAIL rst_underrun: got %0d want 1", nur_a - ua); end
      checks++; if ({lc_a, rc_a} !== 128'h0) begin fails++; $display("FAIL rst_last_cleared: got %h %h want 0", lc_a, rc_a); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_underrun;
      test_back_to_back;
      test_short_lj;
      test_reset_mid_word;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Transmit-side serializer for the WM8731 codec link. Takes one 16-bit left/right sample pair per frame from the pedal-board output path and shifts it onto AUD_DACDAT in I2S format.
- Operates as the mirror of the ADC capture path. The codec is bus master: AUD_BCLK and AUD_DACLRCK are inputs, sampled in the Clk domain.
- Sits between the effects chain (Pedal_Board output) and the codec pins. A one-deep sample buffer with a valid/ready handshake decouples the effects chain from frame timing.

Parameters:
- SAMPLE_W, 16, bits per channel sample, MSB first.
- DATA_DELAY, 1, BCLK slots between a DACLRCK edge and the MSB (1 = I2S, 0 = left-justified).
- UNDERRUN_REPEAT, 1, on underrun: 1 = resend last pair, 0 = send zeros.

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- AUD_BCLK  in  1  codec bit clock, asynchronous to Clk
- AUD_DACLRCK  in  1  codec DAC frame clock, asynchronous to Clk; low = left, high = right
- LDATA  in  SAMPLE_W  left sample, two's complement
- RDATA  in  SAMPLE_W  right sample, two's complement
- data_valid  in  1  LDATA/RDATA valid this cycle
- data_ready  out  1  buffer empty; pair accepted when data_valid && data_ready
- AUD_DACDAT  out  1  serial DAC data
- frame_start  out  1  one-cycle pulse when a left channel begins (buffer consumed)
- underrun  out  1  one-cycle pulse when a frame starts with the buffer empty

Behaviour:
- Synchronization
  - AUD_BCLK and AUD_DACLRCK each pass through a 2-flop synchronizer plus an edge register.
  - bclk_fall is a 1-cycle pulse on a synchronized falling edge.
  - All serializer actions occur only on cycles with bclk_fall.
- Reset (and every output's reset value)
  - AUD_DACDAT=0, data_ready=1, frame_start=0, underrun=0.
  - Buffer is empty, shift register is 0, state is WAIT_SYNC.
  - Reset asserted mid-frame: AUD_DACDAT goes to 0 on the next Clk. Transmission resumes only at the next left-channel start.
- Sample buffer
  - Accept on data_valid && data_ready. The pair is captured and data_ready drops on the next Clk.
  - While data_ready=0, data_valid is ignored.
  - The buffer empties, and data_ready rises the next Clk, only when a left-channel start consumes it.
  - A valid arriving in the same cycle as consumption is not accepted, because ready is still 0.
- LRCK tracking
  - On each bclk_fall, sample the synchronized DACLRCK into lr_prev.
  - A change versus the previous sample marks a channel start.
  - 1->0 is a left start; 0->1 is a right start.
- State machine (SAMPLE_W-wide shift register, bit counter 0..SAMPLE_W+DATA_DELAY)
  - WAIT_SYNC: AUD_DACDAT=0. On a left start, go to LEFT. Right starts are ignored, so a frame never begins mid-pair.
  - LEFT/RIGHT, channel-start bclk_fall:
    - Load the shift register and clear the counter.
    - Left start only: if the buffer is full, load LDATA into the shift register and latch RDATA into a right holding register, then pulse frame_start. If the buffer is empty, pulse underrun and load the last pair (UNDERRUN_REPEAT=1) or zeros.
    - Right start: load the right holding register.
  - LEFT/RIGHT, subsequent bclk_falls:
    - The first DATA_DELAY slots drive 0.
    - The next SAMPLE_W slots drive shift[MSB], shifting left each slot.
    - Remaining slots until the next channel start drive 0.
    - The counter saturates and does not wrap.
  - Short half-frame: if an LRCK edge arrives before all SAMPLE_W bits are sent, abandon the remainder, take the new channel start, and do not raise an error.
  - A right start while in LEFT moves to RIGHT. A left start while in RIGHT moves to LEFT.
- Output timing
  - AUD_DACDAT is registered and updates 1 Clk after bclk_fall.
  - Total latency from the codec BCLK falling edge is 3-4 Clk. This requires a BCLK half-period of at least 6 Clk, which is met at 3.072 MHz.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W default constant
  - tx_state_t enum {WAIT_SYNC, LEFT, RIGHT}
  - a shared sample-pair struct, reusable by the ADC capture side
- Sub-module sync_edge: 2-flop synchronizer plus rise/fall pulse outputs. Instantiated twice (BCLK, DACLRCK), and also reusable on the receive side.

Test Plan:
- Basic pair: BCLK = Clk/16, 64 BCLK/frame, LDATA=16'hA55A, RDATA=16'h1234 valid before the frame -> DACDAT carries A55A MSB-first starting 1 BCLK after LRCK falls, then 1234 after LRCK rises. frame_start pulses once and data_ready returns high.
- Underrun: no valid for a frame following a pair of 8001/7FFE -> underrun pulses and 8001/7FFE is resent. With UNDERRUN_REPEAT=0, 0000/0000 is sent.
- Backpressure: data_valid held high with 3 distinct pairs over 3 frames -> each pair is sent exactly once in order. data_ready is 0 between acceptance and left start, and no pair is lost or duplicated.
- Sync: release reset while LRCK is high (mid-right) -> DACDAT stays 0 until the first LRCK falling edge, and the first transmitted word is the left sample.
- Reset mid-word: assert Reset for 2 Clk during bit 7 of left -> DACDAT is 0 the next cycle, and a buffered pair is discarded (data_ready=1).
- Short frame and left-justified mode: 24 BCLK/half with DATA_DELAY=0, LDATA=16'hFFFF -> MSB appears on the first BCLK after the edge and all 16 bits are sent. With a 10 BCLK/half frame, the word is truncated and the next channel starts cleanly.
